// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, opcode classification helpers and the
// sequencer state encoding.
package alu_pkg;

   localparam logic [4:0] OpAdd  = 5'd1;
   localparam logic [4:0] OpSub  = 5'd2;
   localparam logic [4:0] OpMul  = 5'd3;
   localparam logic [4:0] OpDiv  = 5'd4;
   localparam logic [4:0] OpShr  = 5'd5;
   localparam logic [4:0] OpShl  = 5'd6;
   localparam logic [4:0] OpShra = 5'd7;
   localparam logic [4:0] OpRor  = 5'd8;
   localparam logic [4:0] OpRol  = 5'd9;
   localparam logic [4:0] OpAnd  = 5'd10;
   localparam logic [4:0] OpOr   = 5'd11;
   localparam logic [4:0] OpNeg  = 5'd12;
   localparam logic [4:0] OpXor  = 5'd13;
   localparam logic [4:0] OpNor  = 5'd14;
   localparam logic [4:0] OpNot  = 5'd15;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   function automatic logic op_legal(input logic [4:0] op);
      return (op != 5'd0) && (op <= OpNot);
   endfunction

   // Wide ops produce a full double-width result and take the long wait.
   function automatic logic op_is_wide(input logic [4:0] op);
      return (op == OpMul) || (op == OpDiv);
   endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// 8-bit loadable down-counter that stops at zero; zero flag reflects the
// current count.
module alu_seq_timer (
   input  logic       clk,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 8'd0)) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: accept, drive opcode, capture result,
// hand back over valid/ready. ALU_SEQ_FLAGS_EN adds rsp_zero/rsp_neg outputs.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULDIV_WAIT = 4
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [4:0]         req_op,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [4:0]         alu_opcode,
   input  logic [2*WIDTH-1:0] alu_c,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_lo,
   output logic [WIDTH-1:0]   rsp_hi,
   output logic               rsp_wide,
   output logic               rsp_err,
`ifdef ALU_SEQ_FLAGS_EN
   output logic               rsp_zero,
   output logic               rsp_neg,
`endif
   output logic               busy
);

   localparam logic [7:0] WaitLoad = 8'(MULDIV_WAIT - 1);

   logic [1:0]       state_q, state_d;
   logic [4:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, lo_q, hi_q;
   logic             wide_q, err_q;
   logic             accept, capture, reject;
   logic             tmr_load, tmr_zero;
   logic [7:0]       tmr_val;

   assign accept   = (state_q == StIdle) && req_valid;
   assign reject   = accept && !op_legal(req_op);
   assign capture  = (state_q == StWait) && tmr_zero;
   assign tmr_load = (state_q == StIssue);
   assign tmr_val  = op_is_wide(op_q) ? WaitLoad : 8'd0;

   alu_seq_timer u_timer (
      .clk      (clk),
      .clr      (clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (state_q == StWait),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (req_valid) state_d = op_legal(req_op) ? StIssue : StResp;
         StIssue: state_d = StWait;
         StWait:  if (tmr_zero) state_d = StResp;
         StResp:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= StIdle;
         op_q    <= 5'd0;
         a_q     <= '0;
         b_q     <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         wide_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
         end
         if (reject) begin
            lo_q   <= '0;
            hi_q   <= '0;
            wide_q <= 1'b0;
            err_q  <= 1'b1;
         end else if (capture) begin
            lo_q   <= alu_c[WIDTH-1:0];
            hi_q   <= alu_c[2*WIDTH-1:WIDTH];
            wide_q <= op_is_wide(op_q);
            err_q  <= 1'b0;
         end
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic zero_q, neg_q, cap_zero, cap_neg;

   always_comb begin
      if (op_is_wide(op_q)) begin
         cap_zero = (alu_c == '0);
         cap_neg  = alu_c[2*WIDTH-1];
      end else begin
         cap_zero = (alu_c[WIDTH-1:0] == '0);
         cap_neg  = alu_c[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (clr || reject) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (capture) begin
         zero_q <= cap_zero;
         neg_q  <= cap_neg;
      end
   end

   assign rsp_zero = zero_q;
   assign rsp_neg  = neg_q;
`endif

   assign req_ready  = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign rsp_valid  = (state_q == StResp);
   assign alu_opcode = ((state_q == StIssue) || (state_q == StWait)) ? op_q : 5'd0;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign rsp_lo     = lo_q;
   assign rsp_hi     = hi_q;
   assign rsp_wide   = wide_q;
   assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a transaction-timeline model and a
// behavioural registered ALU; directed cases pin the model to literal values.
module tb_alu_op_sequencer;

   localparam int unsigned WIDTH       = 32;
   localparam int unsigned MULDIV_WAIT = 4;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = 5'd0;
   logic [31:0] req_a = '0, req_b = '0;
   logic [31:0] alu_a, alu_b;
   logic [4:0]  alu_opcode;
   logic [63:0] alu_c = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_lo, rsp_hi;
   logic        rsp_wide, rsp_err, busy;
`ifdef ALU_SEQ_FLAGS_EN
   logic        rsp_zero, rsp_neg;
   logic        cap_zero, cap_neg;
`endif

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(WIDTH), .MULDIV_WAIT(MULDIV_WAIT)) dut (
      .clk        (clk),
      .clr        (clr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_c      (alu_c),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_lo     (rsp_lo),
      .rsp_hi     (rsp_hi),
      .rsp_wide   (rsp_wide),
      .rsp_err    (rsp_err),
`ifdef ALU_SEQ_FLAGS_EN
      .rsp_zero   (rsp_zero),
      .rsp_neg    (rsp_neg),
`endif
      .busy       (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural ALU: non-wide ops put ~a in the upper half so verbatim copying shows.
   function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] lo;
      logic [4:0]  s;
      s  = b[4:0];
      lo = '0;
      case (op)
         5'd1:  lo = a + b;
         5'd2:  lo = a - b;
         5'd3:  return {32'd0, a} * {32'd0, b};
         5'd4:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         5'd5:  lo = a >> s;
         5'd6:  lo = a << s;
         5'd7:  lo = $unsigned($signed(a) >>> s);
         5'd8:  lo = (a >> s) | (a << (6'd32 - {1'b0, s}));
         5'd9:  lo = (a << s) | (a >> (6'd32 - {1'b0, s}));
         5'd10: lo = a & b;
         5'd11: lo = a | b;
         5'd12: lo = -a;
         5'd13: lo = a ^ b;
         5'd14: lo = ~(a | b);
         5'd15: lo = ~a;
         default: lo = '0;
      endcase
      return {~a, lo};
   endfunction

   always @(posedge clk) begin
      if (alu_opcode != 5'd0) alu_c <= alu_f(alu_opcode, alu_a, alu_b);
   end

   // Timeline model: m_t counts cycles since the accept edge; response due at m_lat.
   bit          m_active = 0, m_fresh = 1, m_legal = 1, m_wide = 0;
   int          m_t = 0, m_lat = 0;
   logic [4:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0;
   logic [63:0] m_res = '0;

   initial begin
      forever begin
         @(posedge clk);
         if (clr) begin
            m_active = 0; m_fresh = 1; m_legal = 1; m_wide = 0;
            m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_t = 0; m_lat = 0;
         end else if (!m_active) begin
            if (req_valid) begin
               m_active = 1; m_fresh = 0; m_t = 1;
               m_op = req_op; m_a = req_a; m_b = req_b;
               m_legal = (req_op >= 5'd1) && (req_op <= 5'd15);
               m_wide  = m_legal && (req_op == 5'd3 || req_op == 5'd4);
               m_lat   = !m_legal ? 1 : (m_wide ? int'(MULDIV_WAIT) + 2 : 3);
               m_res   = m_legal ? alu_f(req_op, req_a, req_b) : 64'd0;
            end
         end else if (m_t >= m_lat && rsp_ready) begin
            m_active = 0;
         end else begin
            m_t++;
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("req_ready", req_ready, !m_active);
         chk("busy", busy, m_active);
         chk("rsp_valid", rsp_valid, m_active && (m_t >= m_lat));
         chk("alu_opcode", alu_opcode, (m_active && m_legal && m_t < m_lat) ? m_op : 5'd0);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         if (m_fresh || (m_active && m_t >= m_lat)) begin
            chk("rsp_lo", rsp_lo, m_res[31:0]);
            chk("rsp_hi", rsp_hi, m_res[63:32]);
            chk("rsp_wide", rsp_wide, m_wide);
            chk("rsp_err", rsp_err, !m_legal);
`ifdef ALU_SEQ_FLAGS_EN
            chk("rsp_zero", rsp_zero, !m_fresh && m_legal &&
                (m_wide ? (m_res == 64'd0) : (m_res[31:0] == 32'd0)));
            chk("rsp_neg", rsp_neg, !m_fresh && m_legal && (m_wide ? m_res[63] : m_res[31]));
`endif
         end
      end
   end

   // One transaction; DUT must be idle on entry. Inputs change #1 after posedge.
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit noise, output int lat,
                        output logic [63:0] res, output logic err, output logic wide);
      int c;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(posedge clk); #1;
      c = 1;
      req_valid = 1'b0;
      while (!rsp_valid && c < 400) begin
         if (noise) begin
            req_valid = 1'($urandom_range(0, 1));
            rsp_ready = 1'($urandom_range(0, 1));
            req_op = 5'($urandom); req_a = $urandom; req_b = $urandom;
         end
         @(posedge clk); #1;
         c++;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1'b1);
      lat = c; res = {rsp_hi, rsp_lo}; err = rsp_err; wide = rsp_wide;
`ifdef ALU_SEQ_FLAGS_EN
      cap_zero = rsp_zero; cap_neg = rsp_neg;
`endif
      repeat (hold) begin @(posedge clk); #1; end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int          lat;
      logic [63:0] res;
      logic        err, wide;

      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_opcode", alu_opcode, 5'd0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);

      do_op(5'd1, 32'd5, 32'd7, 0, 0, lat, res, err, wide);
      chk("add_lat", lat, 3);
      chk("add_lo", res[31:0], 32'd12);
      chk("add_wide", wide, 1'b0);
      chk("add_err", err, 1'b0);

      do_op(5'd3, 32'd2, 32'h8000_0001, 0, 0, lat, res, err, wide);
      chk("mul_lat", lat, 6);
      chk("mul_res", res, 64'h0000_0001_0000_0002);
      chk("mul_wide", wide, 1'b1);

      do_op(5'd2, 32'd100, 32'd1, 5, 0, lat, res, err, wide);
      chk("bp_lat", lat, 3);
      chk("bp_lo", res[31:0], 32'd99);
      chk("bp_after_valid", rsp_valid, 1'b0);
      chk("bp_after_ready", req_ready, 1'b1);

      do_op(5'd0, 32'd1, 32'd2, 0, 0, lat, res, err, wide);
      chk("ill0_lat", lat, 1);
      chk("ill0_err", err, 1'b1);
      chk("ill0_res", res, 64'd0);
      do_op(5'd20, 32'd3, 32'd4, 1, 0, lat, res, err, wide);
      chk("ill20_lat", lat, 1);
      chk("ill20_err", err, 1'b1);
      chk("ill20_res", res, 64'd0);

      // Abort a div in its second WAIT cycle; a request during clr must be ignored.
      req_valid = 1'b1; req_op = 5'd4; req_a = 32'd100; req_b = 32'd7;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr = 1'b1; req_valid = 1'b1; req_op = 5'd1; req_a = 32'd9; req_b = 32'd9;
      @(posedge clk); #1;
      clr = 1'b0; req_valid = 1'b0;
      chk("clr_opcode", alu_opcode, 5'd0);
      chk("clr_rsp_valid", rsp_valid, 1'b0);
      chk("clr_req_ready", req_ready, 1'b1);
      chk("clr_busy", busy, 1'b0);
      do_op(5'd1, 32'd2, 32'd2, 0, 0, lat, res, err, wide);
      chk("post_clr_lat", lat, 3);
      chk("post_clr_lo", res[31:0], 32'd4);

`ifdef ALU_SEQ_FLAGS_EN
      do_op(5'd2, 32'd3, 32'd3, 0, 0, lat, res, err, wide);
      chk("sub0_zero", cap_zero, 1'b1);
      chk("sub0_neg", cap_neg, 1'b0);
      do_op(5'd2, 32'd0, 32'd1, 0, 0, lat, res, err, wide);
      chk("subneg_lo", res[31:0], 32'hFFFF_FFFF);
      chk("subneg_neg", cap_neg, 1'b1);
      chk("subneg_zero", cap_zero, 1'b0);
`endif

      for (int i = 0; i < 300; i++) begin
         logic [4:0]  op;
         logic [31:0] a, b;
         op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(1, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         do_op(op, a, b, int'($urandom_range(0, 3)), 1, lat, res, err, wide);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
